// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: EX/MEM/WB destination scoreboard with per-operand
// forwarding selects. It also generates the load-use stall and the
// multi-cycle branch flush, and keeps saturating stall/flush counters.
// fwd_sel encoding per slot: 0=RF, 1=EX, 2=MEM, 3=WB.
module hazard_scoreboard #(
   parameter int NUM_SRC        = 3,
   parameter int REG_W          = 4,
   parameter int BRANCH_PENALTY = 1,
   parameter int CNT_W          = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     id_valid,
   input  logic [NUM_SRC*REG_W-1:0] id_src_reg,
   input  logic [NUM_SRC-1:0]       id_src_used,
   input  logic [REG_W-1:0]         id_dst_reg,
   input  logic                     id_rf_enable,
   input  logic                     id_load,
   input  logic                     branch_taken,
   output logic [2*NUM_SRC-1:0]     fwd_sel,
   output logic                     stall,
   output logic                     flush_ifid,
   output logic                     bubble_ex,
   output logic [CNT_W-1:0]         perf_stalls,
   output logic [CNT_W-1:0]         perf_flushes
);

   // One in-flight destination per downstream stage.
   typedef struct packed {
      logic             v;
      logic [REG_W-1:0] rd;
      logic             we;
      logic             ld;
   } sb_entry_t;

   localparam logic [2:0] FLUSH_RELOAD = 3'(BRANCH_PENALTY - 1);

   sb_entry_t           ex_q, mem_q, wb_q;
   logic [2:0]          flush_cnt;
   logic [CNT_W-1:0]    stall_cnt, flush_tot;

   logic [NUM_SRC-1:0]   hit_ex, hit_mem, hit_wb;
   logic [2*NUM_SRC-1:0] fwd_raw;
   logic                 load_use;
   logic                 flush_active;
   logic                 stall_int;
   logic                 bubble_int;

   // Per-slot match against each stage and forwarding priority EX > MEM > WB > RF.
   always_comb begin
      // NOTE: every combinational output gets a default before the loop so no
      // path leaves it unassigned, which would otherwise infer a latch.
      hit_ex   = '0;
      hit_mem  = '0;
      hit_wb   = '0;
      fwd_raw  = '0;
      load_use = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         hit_ex[i]  = id_src_used[i] & ex_q.v  & ex_q.we  & (ex_q.rd  == id_src_reg[i*REG_W +: REG_W]);
         hit_mem[i] = id_src_used[i] & mem_q.v & mem_q.we & (mem_q.rd == id_src_reg[i*REG_W +: REG_W]);
         hit_wb[i]  = id_src_used[i] & wb_q.v  & wb_q.we  & (wb_q.rd  == id_src_reg[i*REG_W +: REG_W]);
         // A load in EX has no data yet: it is never a forwarding source.
         if (hit_ex[i] & ex_q.ld) begin
            load_use = 1'b1;
         end
         if (hit_ex[i] & ~ex_q.ld) begin
            fwd_raw[2*i +: 2] = 2'd1;
         end else if (hit_mem[i]) begin
            fwd_raw[2*i +: 2] = 2'd2;
         end else if (hit_wb[i]) begin
            fwd_raw[2*i +: 2] = 2'd3;
         end
      end
   end

   // A taken branch (or a pending penalty) overrides the load-use stall.
   assign flush_active = branch_taken | (flush_cnt != 3'd0);
   assign stall_int    = id_valid & load_use & ~flush_active;
   assign bubble_int   = (id_valid & load_use) | flush_active;

   // Reset forces every output low regardless of register contents.
   assign fwd_sel      = reset ? '0 : fwd_raw;
   assign stall        = ~reset & stall_int;
   assign flush_ifid   = ~reset & flush_active;
   assign bubble_ex    = ~reset & bubble_int;
   assign perf_stalls  = reset ? '0 : stall_cnt;
   assign perf_flushes = reset ? '0 : flush_tot;

   // Advance the scoreboard, the flush penalty counter and the perf counters.
   always_ff @(posedge clk) begin
      // NOTE: state uses non-blocking assignments so WB<=MEM<=EX shifts
      // read the pre-edge values, independent of statement order.
      if (reset) begin
         ex_q      <= '0;
         mem_q     <= '0;
         wb_q      <= '0;
         flush_cnt <= 3'd0;
         stall_cnt <= '0;
         flush_tot <= '0;
      end else begin
         wb_q     <= mem_q;
         mem_q    <= ex_q;
         ex_q.v   <= id_valid & ~bubble_int;
         ex_q.rd  <= id_dst_reg;
         ex_q.we  <= id_rf_enable;
         ex_q.ld  <= id_load;

         if (branch_taken) begin
            flush_cnt <= FLUSH_RELOAD;
         end else if (flush_cnt != 3'd0) begin
            flush_cnt <= flush_cnt - 3'd1;
         end

         if (stall_int && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
         if (flush_active && (flush_tot != '1)) begin
            flush_tot <= flush_tot + 1'b1;
         end
      end
   end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the single-cycle HazardUnit. Holds its own EX/MEM/WB destination scoreboard and drives forwarding selects for NUM_SRC source operands (default PA/PB/PD).
- Generates the load-use stall and the multi-cycle branch flush, and keeps a saturating stall/flush performance counter.
- Sits between ID decode and the MUX_PA/PB/PD forwarding muxes, the PC enable and the IF/ID register.

Parameters:
- NUM_SRC, 3, number of source operand ports checked and forwarded.
- REG_W, 4, register-number width.
- BRANCH_PENALTY, 1, cycles flush_ifid stays high per taken branch (1..7).
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- id_valid  in  1  ID stage holds a real instruction.
- id_src_reg  in  NUM_SRC*REG_W  source register numbers; slot i = bits [i*REG_W +: REG_W].
- id_src_used  in  NUM_SRC  slot i is actually read by the instruction.
- id_dst_reg  in  REG_W  destination register (Rd, or 14 for BL).
- id_rf_enable  in  1  ID instruction writes the register file.
- id_load  in  1  ID instruction is a load.
- branch_taken  in  1  taken branch resolved in EX this cycle.
- fwd_sel  out  2*NUM_SRC  per slot: 0=RF, 1=EX, 2=MEM, 3=WB (S_PA encoding).
- stall  out  1  hold PC and IF/ID.
- flush_ifid  out  1  clear IF/ID.
- bubble_ex  out  1  inject NOP into ID/EX.
- perf_stalls  out  CNT_W  count of cycles with stall=1.
- perf_flushes  out  CNT_W  count of cycles with flush_ifid=1.

Behaviour:
- Scoreboard: three entries EX, MEM, WB. Each entry holds {v, rd, we, ld}.
- Each non-reset edge:
  - WB<=MEM, MEM<=EX.
  - EX<={id_valid & ~bubble_ex, id_dst_reg, id_rf_enable, id_load}.
  - If bubble_ex=1, the EX entry gets v=0.
- Matching and forwarding (combinational):
  - Slot i matches stage S when id_src_used[i] & S.v & S.we & (rd==id_src_reg[i]).
  - fwd_sel priority is EX > MEM > WB > RF.
  - Unused slots read 0.
- Load-use:
  - Any used slot matching EX with EX.ld=1 drives stall=1 and bubble_ex=1.
  - That slot's fwd_sel falls to MEM/WB/RF priority; an EX load is never selected.
  - Next cycle the load is in MEM, the stall drops and fwd_sel=2.
- Branch:
  - branch_taken=1 drives flush_ifid=1 and bubble_ex=1 that cycle.
  - It also loads flush_cnt<=BRANCH_PENALTY-1. While flush_cnt!=0, flush_ifid=1 and bubble_ex=1, and flush_cnt decrements each cycle.
  - branch_taken during an active flush reloads the counter.
- Simultaneous branch and load-use: flush wins, stall=0, bubble_ex=1.
- Counters: each saturates at all-ones and never wraps.
- Reset:
  - All entries v=0, flush_cnt=0, both counters 0.
  - While reset=1, every output is forced 0.
  - Reset asserted mid-flush or mid-stall aborts it on the next edge.
- No id_valid gating on sources: an invalid ID instruction with used slots still produces forwarding, but stalls only if id_valid=1.

Test Plan:
- ADD R1 then SUB R2,R1,R3 next cycle -> slot0 fwd_sel=1, stall=0. Same check with one and two NOPs between -> fwd_sel=2, then 3.
- LDR R4 then ADD R5,R4,R4 -> one cycle stall=1, bubble_ex=1, fwd_sel slots0/1 != 1. Next cycle stall=0 and fwd_sel=2 on both slots; perf_stalls=1.
- R1 written in EX (ADD) and in MEM (older MOV), ID reads R1 -> fwd_sel=1 (youngest wins).
- BRANCH_PENALTY=3, branch_taken pulse -> flush_ifid high exactly 3 cycles. Second pulse in cycle 2 -> high through cycle 4; perf_flushes=5.
- Load-use and branch_taken in the same cycle -> stall=0, flush_ifid=1, bubble_ex=1, perf_stalls unchanged.
- Reset mid-flush (counter=2) -> outputs 0 during reset, flush_ifid=0 after release. Preload counters near max (CNT_W=4) -> perf_stalls holds at 15.
